md_unit: RTL
============

MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL expose parameter MULT_CYCLES, default 5, busy duration in cycles for mult/multu.
REQ-002 The block SHALL expose parameter DIV_CYCLES, default 10, busy duration in cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op_valid  input  1  qualifies md_op for the current cycle.
REQ-006 md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-007 srcA  input  32  GRF rs operand; dividend, multiplicand, or mthi/mtlo data.
REQ-008 srcB  input  32  GRF rt operand; divisor or multiplier.
REQ-009 busy  output  1  high while a multiply or divide is in flight.
REQ-010 done  output  1  one-cycle pulse in the cycle HI/LO first show a new mult/div result.
REQ-011 HI  output  32  HI register, registered.
REQ-012 LO  output  32  LO register, registered.

Function
REQ-013 States SHALL be IDLE and RUN; IDLE->RUN on accepted mult/div; RUN->IDLE when the down-counter reaches 1.
REQ-014 An op SHALL be accepted only when op_valid=1 and busy=0; while busy=1 every op, including mthi/mtlo, SHALL be ignored with no state change.
REQ-015 On accepting mult/multu/div/divu, srcA, srcB and the op SHALL be latched; later operand changes SHALL have no effect.
REQ-016 busy SHALL go high the cycle after acceptance and stay high for exactly MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu) cycles.
REQ-017 HI/LO SHALL update on the clock edge that drops busy; done SHALL be high for exactly the following cycle.
REQ-018 During RUN, HI and LO SHALL hold their pre-operation values.
REQ-019 mult: {HI,LO} = signed 32x32 -> 64-bit product; multu: unsigned 64-bit product.
REQ-020 div: LO = signed quotient truncated toward zero, HI = remainder with the dividend's sign; divu: unsigned quotient/remainder.
REQ-021 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-022 Divide by zero (srcB=0) SHALL still run the full DIV_CYCLES busy window, then leave HI/LO unchanged; done SHALL still pulse.
REQ-023 mthi/mtlo SHALL write srcA into HI/LO at the accepting edge, with no busy and no done.
REQ-024 A new op SHALL be acceptable in the cycle busy is low after completion, i.e. the done cycle; back-to-back ops SHALL lose no cycle.
REQ-025 md_op=0 or 7 with op_valid=1 SHALL have no effect.

Reset
REQ-026 On reset=1 at a rising edge, HI=0, LO=0, busy=0, done=0, state=IDLE, counter=0.
REQ-027 Reset during RUN SHALL abort the operation; no HI/LO update and no done pulse occur afterwards.
REQ-028 Reset SHALL take priority over any simultaneous op acceptance.

Configuration
REQ-029 Macro MD_UNIT_DIV_EN SHALL gate divide support.
REQ-030 With MD_UNIT_DIV_EN defined, div/divu SHALL behave per REQ-016..REQ-022.
REQ-031 Without it, div/divu SHALL be treated as none: no busy, no done, HI/LO unchanged; mult/multu/mthi/mtlo are unaffected.

Verification
REQ-032 mult srcA=0xFFFFFFFE(-2), srcB=3 -> busy for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, done for 1 cycle.
REQ-033 multu srcA=0xFFFFFFFF, srcB=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-034 div srcA=0xFFFFFFF9(-7), srcB=2 -> busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> busy 10, HI/LO unchanged (MD_UNIT_DIV_EN defined).
REQ-035 mtlo 0x12345678 while busy -> ignored; mtlo after done -> LO=0x12345678 at next edge, busy stays 0.
REQ-036 Reset asserted at busy cycle 3 of a mult -> next cycle busy=0, HI=LO=0, and done never pulses.
REQ-037 Build without MD_UNIT_DIV_EN; div 8/2 -> busy stays 0, HI/LO unchanged; mult 8*2 -> LO=0x10 after 5 cycles.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle HI/LO multiply/divide unit; div/divu exist only when MD_UNIT_DIV_EN is defined
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
`ifdef MD_UNIT_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif
    logic [0:0]         state;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [31:0]        a_q, b_q, sdiv_b, udiv_b;
    logic signed [31:0] sq, sr;
    logic [63:0]        ext_a, ext_b, prod, res;
    logic               is_mul, is_div, sgn, last, div_zero;

    assign busy     = state == RUN;
    assign is_mul   = md_op == OP_MULT || md_op == OP_MULTU;
    assign is_div   = DIV_EN && (md_op == OP_DIV || md_op == OP_DIVU);
    assign sgn      = op_q == OP_MULT;
    assign ext_a    = {{32{sgn & a_q[31]}}, a_q};
    assign ext_b    = {{32{sgn & b_q[31]}}, b_q};
    assign prod     = ext_a * ext_b;
    // Divisor forced to 1 for /0 (result discarded) and INT_MIN/-1 (quotient is INT_MIN, remainder 0)
    assign udiv_b   = (b_q == 32'd0) ? 32'd1 : b_q;
    assign sdiv_b   = (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) ? 32'd1 : udiv_b;
    assign sq       = $signed(a_q) / $signed(sdiv_b);
    assign sr       = $signed(a_q) % $signed(sdiv_b);
    assign res      = (op_q == OP_DIV) ? {sr, sq} : (op_q == OP_DIVU) ? {a_q % udiv_b, a_q / udiv_b} : prod;
    assign last     = busy && cnt == CW'(1);
    assign div_zero = (op_q == OP_DIV || op_q == OP_DIVU) && b_q == 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            HI    <= '0;
            LO    <= '0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (busy) begin
                cnt <= cnt - CW'(1);
                if (last) begin
                    state <= IDLE;
                    if (!div_zero) {HI, LO} <= res;
                end
            end else if (op_valid && (is_mul || is_div)) begin
                state <= RUN;
                cnt   <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                op_q  <= md_op;
                a_q   <= srcA;
                b_q   <= srcB;
            end else if (op_valid && md_op == OP_MTHI) begin
                HI <= srcA;
            end else if (op_valid && md_op == OP_MTLO) begin
                LO <= srcA;
            end
        end
    end
endmodule
